// File: rtl/onchip_ram_pkg.sv
// rtl/onchip_ram_pkg.sv - clear FSM states, width helper and read latency (ONCHIP_RAM_OUTREG_EN)
package onchip_ram_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

`ifdef ONCHIP_RAM_OUTREG_EN
    localparam int READ_LATENCY = 2;
`else
    localparam int READ_LATENCY = 1;
`endif

    function automatic int clog2_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/onchip_ram_dp_core.sv
// rtl/onchip_ram_dp_core.sv - behavioural true-dual-port byte-enabled array
module onchip_ram_dp_core #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 23040,
    parameter int IDX_W     = 15,
    parameter     INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_we,
    input  logic                a_re,
    input  logic [IDX_W-1:0]    a_addr,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_rdata,
    input  logic                b_we,
    input  logic                b_re,
    input  logic [IDX_W-1:0]    b_addr,
    input  logic [DATA_W/8-1:0] b_be,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic [DATA_W-1:0]   b_rdata
);
    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Port B lanes are written first so port A overrides them on overlap.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (b_we && b_be[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
        end
        for (int i = 0; i < BE_W; i++) begin
            if (a_we && a_be[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
        end
    end

    // Reads sample the array before this edge's writes land: old-data behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_re) a_rdata <= mem[a_addr];
            if (b_re) b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/onchip_ram_dp.sv
// rtl/onchip_ram_dp.sv - dual-port Avalon-MM RAM with zero-fill sequencer; ONCHIP_RAM_OUTREG_EN adds an output register
module onchip_ram_dp
    import onchip_ram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 23040,
    parameter int ADDR_W         = clog2_w(DEPTH),
    parameter     INIT_FILE      = "",
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_req,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic                s1_waitrequest,
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    output logic                s2_waitrequest,
    output logic                init_done
);
    localparam int              BE_W    = DATA_W / 8;
    localparam int              IDX_W   = clog2_w(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    clr_state_e       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             busy;
    logic             clr_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLR_IDLE: begin
                cnt_d   = '0;
                state_d = CLEAR_ON_RESET ? CLR_CLEAR : CLR_DONE;
            end
            CLR_CLEAR: begin
                if (!reset_req) begin
                    if (cnt_q == LAST_IDX) state_d = CLR_DONE;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
            end
            CLR_DONE: ;
            default: state_d = CLR_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b1;
        init_done = 1'b0;
        clr_we    = 1'b0;
        case (state_q)
            CLR_CLEAR: clr_we = ~reset_req;
            CLR_DONE: begin
                busy      = reset_req;
                init_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign s1_waitrequest = busy;
    assign s2_waitrequest = busy;

    // Port index 0 is s1, index 1 is s2.
    logic [1:0]        cs, rd, wr, acc_rd, acc_wr, in_rng;
    logic [ADDR_W-1:0] addr [2];

    assign cs      = {s2_chipselect, s1_chipselect};
    assign rd      = {s2_read, s1_read};
    assign wr      = {s2_write, s1_write};
    assign addr[0] = s1_address;
    assign addr[1] = s2_address;

    always_comb begin
        acc_rd = '0;
        acc_wr = '0;
        in_rng = '0;
        for (int p = 0; p < 2; p++) begin
            in_rng[p] = {1'b0, addr[p]} < DEPTH_L;
            acc_wr[p] = cs[p] & wr[p] & ~busy;
            acc_rd[p] = cs[p] & rd[p] & ~wr[p] & ~busy;
        end
    end

    logic [DATA_W-1:0] mem_q [2];
    logic              a_we;
    logic [IDX_W-1:0]  a_addr;
    logic [BE_W-1:0]   a_be;
    logic [DATA_W-1:0] a_wdata;

    // The sequencer borrows port A; it never overlaps a host command since busy is high.
    always_comb begin
        a_we    = acc_wr[0] & in_rng[0];
        a_addr  = s1_address[IDX_W-1:0];
        a_be    = s1_byteenable;
        a_wdata = s1_writedata;
        if (clr_we) begin
            a_we    = 1'b1;
            a_addr  = cnt_q;
            a_be    = '1;
            a_wdata = '0;
        end
    end

    onchip_ram_dp_core #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W),
        .INIT_FILE (INIT_FILE)
    ) u_core (
        .clk     (clk),
        .rst     (reset),
        .a_we    (a_we),
        .a_re    (acc_rd[0] & in_rng[0]),
        .a_addr  (a_addr),
        .a_be    (a_be),
        .a_wdata (a_wdata),
        .a_rdata (mem_q[0]),
        .b_we    (acc_wr[1] & in_rng[1]),
        .b_re    (acc_rd[1] & in_rng[1]),
        .b_addr  (s2_address[IDX_W-1:0]),
        .b_be    (s2_byteenable),
        .b_wdata (s2_writedata),
        .b_rdata (mem_q[1])
    );

    logic [1:0]        rv1_q, oob_q;
    logic [DATA_W-1:0] d1 [2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rv1_q <= '0;
            oob_q <= '0;
        end else if (!reset_req) begin
            rv1_q <= acc_rd;
            for (int p = 0; p < 2; p++) begin
                if (acc_rd[p]) oob_q[p] <= ~in_rng[p];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) d1[p] = oob_q[p] ? '0 : mem_q[p];
    end

    logic [1:0]        rv_out;
    logic [DATA_W-1:0] rd_out [2];

    generate
        if (READ_LATENCY > 1) begin : g_outreg
            logic [1:0]        rv2_q;
            logic [DATA_W-1:0] rd2_q [2];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rv2_q    <= '0;
                    rd2_q[0] <= '0;
                    rd2_q[1] <= '0;
                end else if (!reset_req) begin
                    rv2_q <= rv1_q;
                    for (int p = 0; p < 2; p++) begin
                        if (rv1_q[p]) rd2_q[p] <= d1[p];
                    end
                end
            end

            assign rv_out    = rv2_q;
            assign rd_out[0] = rd2_q[0];
            assign rd_out[1] = rd2_q[1];
        end else begin : g_direct
            assign rv_out    = rv1_q;
            assign rd_out[0] = d1[0];
            assign rd_out[1] = d1[1];
        end
    endgenerate

    assign s1_readdata      = rd_out[0];
    assign s2_readdata      = rd_out[1];
    assign s1_readdatavalid = rv_out[0];
    assign s2_readdatavalid = rv_out[1];

endmodule

// File: tb/tb_onchip_ram_dp.sv
// tb/tb_onchip_ram_dp.sv - randomized bench for onchip_ram_dp against an array reference model
module tb_onchip_ram_dp;
`ifdef ONCHIP_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = 16;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset, reset_req;
    logic [AW-1:0] s1_address, s2_address;
    logic          s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
    logic [3:0]    s1_byteenable, s2_byteenable;
    logic [31:0]   s1_writedata, s2_writedata, s1_readdata, s2_readdata;
    logic          s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest;
    logic          init_done;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    onchip_ram_dp #(
        .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(AW), .INIT_FILE(""), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest),
        .init_done(init_done)
    );

    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) ? model[a[3:0]] : 32'h0;
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        if (int'(a) < DEPTH) begin
            for (int i = 0; i < 4; i++) if (be[i]) model[a[3:0]][8*i +: 8] = d[8*i +: 8];
        end
    endfunction

    task automatic idle_bus();
        s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
        s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
    endtask

    // One command cycle on both ports, then wait until read results are due.
    task automatic bus_cycle(
        input logic c1, r1, w1, input logic [AW-1:0] a1, input logic [3:0] be1, input logic [31:0] d1,
        input logic c2, r2, w2, input logic [AW-1:0] a2, input logic [3:0] be2, input logic [31:0] d2,
        output logic [31:0] q1, q2, output logic v1, v2);
        s1_chipselect = c1; s1_read = r1; s1_write = w1; s1_address = a1; s1_byteenable = be1; s1_writedata = d1;
        s2_chipselect = c2; s2_read = r2; s2_write = w2; s2_address = a2; s2_byteenable = be2; s2_writedata = d2;
        @(posedge clk); #1;
        idle_bus();
        repeat (LAT - 1) begin @(posedge clk); #1; end
        q1 = s1_readdata; q2 = s2_readdata; v1 = s1_readdatavalid; v2 = s2_readdatavalid;
    endtask

    // Releases reset and counts cycles until init_done, bounded.
    task automatic wait_clear(output int first, output bit early);
        first = 0; early = 0;
        reset = 0;
        for (int c = 1; c <= 100 && first == 0; c++) begin
            @(posedge clk); #1;
            if (init_done) first = c;
            else if (!s1_waitrequest || !s2_waitrequest) early = 1;
        end
    endtask

    task automatic test_reset();
        int first; bit early;
        reset = 1; reset_req = 0; idle_bus();
        repeat (3) @(posedge clk); #1;
        total++; if (s1_readdata !== 32'h0) begin bad++; $display("FAIL rst_rd1 got=%h exp=0", s1_readdata); end
        total++; if (s2_readdata !== 32'h0) begin bad++; $display("FAIL rst_rd2 got=%h exp=0", s2_readdata); end
        total++; if (s1_readdatavalid !== 1'b0) begin bad++; $display("FAIL rst_rv1 got=%b exp=0", s1_readdatavalid); end
        total++; if (s2_readdatavalid !== 1'b0) begin bad++; $display("FAIL rst_rv2 got=%b exp=0", s2_readdatavalid); end
        total++; if (s1_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wr1 got=%b exp=1", s1_waitrequest); end
        total++; if (s2_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wr2 got=%b exp=1", s2_waitrequest); end
        total++; if (init_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", init_done); end
        wait_clear(first, early);
        total++; if (first !== DEPTH + 1) begin bad++; $display("FAIL clear_len got=%0d exp=%0d", first, DEPTH + 1); end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL clear_wait got=%b exp=0", early); end
        total++; if (s1_waitrequest !== 1'b0 || s2_waitrequest !== 1'b0) begin
            bad++; $display("FAIL ready_wait got=%b%b exp=00", s1_waitrequest, s2_waitrequest);
        end
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    task automatic test_clear_zero();
        logic [31:0] q1, q2; logic v1, v2;
        for (int a = 0; a < DEPTH; a++) begin
            bus_cycle(1, 1, 0, AW'(a), 4'h0, 32'h0, 1, 1, 0, AW'(DEPTH - 1 - a), 4'h0, 32'h0, q1, q2, v1, v2);
            total++; if (v1 !== 1'b1 || q1 !== 32'h0) begin bad++; $display("FAIL zero_s1 a=%0d got=%b/%h exp=1/0", a, v1, q1); end
            total++; if (v2 !== 1'b1 || q2 !== 32'h0) begin bad++; $display("FAIL zero_s2 a=%0d got=%b/%h exp=1/0", DEPTH - 1 - a, v2, q2); end
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] q1, q2, d, exp; logic v1, v2; logic [AW-1:0] a; logic [3:0] be;
        bus_cycle(1, 0, 1, 5'd5, 4'hF, 32'h11223344, 0, 0, 0, '0, '0, '0, q1, q2, v1, v2);
        model_write(5'd5, 32'h11223344, 4'hF);
        total++; if (v1 !== 1'b0) begin bad++; $display("FAIL wr_novalid got=%b exp=0", v1); end
        bus_cycle(1, 0, 1, 5'd5, 4'b0101, 32'hDEADBEEF, 0, 0, 0, '0, '0, '0, q1, q2, v1, v2);
        model_write(5'd5, 32'hDEADBEEF, 4'b0101);
        bus_cycle(0, 0, 0, '0, '0, '0, 1, 1, 0, 5'd5, 4'h0, 32'h0, q1, q2, v1, v2);
        total++; if (v2 !== 1'b1 || q2 !== 32'h11AD33EF) begin bad++; $display("FAIL be_merge got=%b/%h exp=1/11ad33ef", v2, q2); end
        for (int k = 0; k < 10; k++) begin
            a = AW'($urandom_range(0, DEPTH - 1)); be = 4'($urandom_range(0, 15)); d = $urandom;
            if (k[0]) bus_cycle(1, 0, 1, a, be, d, 0, 0, 0, '0, '0, '0, q1, q2, v1, v2);
            else      bus_cycle(0, 0, 0, '0, '0, '0, 1, 0, 1, a, be, d, q1, q2, v1, v2);
            model_write(a, d, be);
            exp = model_read(a);
            bus_cycle(1, 1, 0, a, 4'h0, 32'h0, 0, 0, 0, '0, '0, '0, q1, q2, v1, v2);
            total++; if (v1 !== 1'b1 || q1 !== exp) begin bad++; $display("FAIL be_rand a=%0d got=%b/%h exp=1/%h", a, v1, q1, exp); end
        end
    endtask

    task automatic test_write_collision();
        logic [31:0] q1, q2, d1, d2, exp; logic v1, v2; logic [AW-1:0] a; logic [3:0] b1, b2;
        bus_cycle(1, 0, 1, 5'd3, 4'hF, 32'hAAAAAAAA, 1, 0, 1, 5'd3, 4'hF, 32'h55555555, q1, q2, v1, v2);
        model_write(5'd3, 32'h55555555, 4'hF); model_write(5'd3, 32'hAAAAAAAA, 4'hF);
        bus_cycle(0, 0, 0, '0, '0, '0, 1, 1, 0, 5'd3, 4'h0, 32'h0, q1, q2, v1, v2);
        total++; if (v2 !== 1'b1 || q2 !== 32'hAAAAAAAA) begin bad++; $display("FAIL ww_same got=%b/%h exp=1/aaaaaaaa", v2, q2); end
        for (int k = 0; k < 6; k++) begin
            a = AW'($urandom_range(0, DEPTH - 1)); b1 = 4'($urandom_range(0, 15)); b2 = 4'($urandom_range(0, 15));
            d1 = $urandom; d2 = $urandom;
            bus_cycle(1, 0, 1, a, b1, d1, 1, 0, 1, a, b2, d2, q1, q2, v1, v2);
            for (int i = 0; i < 4; i++) begin
                if (b1[i])      model[a[3:0]][8*i +: 8] = d1[8*i +: 8];
                else if (b2[i]) model[a[3:0]][8*i +: 8] = d2[8*i +: 8];
            end
            exp = model_read(a);
            bus_cycle(1, 1, 0, a, 4'h0, 32'h0, 0, 0, 0, '0, '0, '0, q1, q2, v1, v2);
            total++; if (v1 !== 1'b1 || q1 !== exp) begin bad++; $display("FAIL ww_rand a=%0d got=%b/%h exp=1/%h", a, v1, q1, exp); end
        end
    endtask

    task automatic test_read_write_collision();
        logic [31:0] q1, q2; logic v1, v2;
        bus_cycle(1, 0, 1, 5'd7, 4'hF, 32'h1, 0, 0, 0, '0, '0, '0, q1, q2, v1, v2);
        model_write(5'd7, 32'h1, 4'hF);
        bus_cycle(1, 0, 1, 5'd7, 4'hF, 32'h2, 1, 1, 0, 5'd7, 4'h0, 32'h0, q1, q2, v1, v2);
        model_write(5'd7, 32'h2, 4'hF);
        total++; if (v2 !== 1'b1 || q2 !== 32'h1) begin bad++; $display("FAIL rw_old got=%b/%h exp=1/1", v2, q2); end
        total++; if (v1 !== 1'b0) begin bad++; $display("FAIL rw_wrvalid got=%b exp=0", v1); end
        bus_cycle(0, 0, 0, '0, '0, '0, 1, 1, 0, 5'd7, 4'h0, 32'h0, q1, q2, v1, v2);
        total++; if (v2 !== 1'b1 || q2 !== 32'h2) begin bad++; $display("FAIL rw_new got=%b/%h exp=1/2", v2, q2); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] q1, q2, exp; logic v1, v2;
        bus_cycle(1, 0, 1, 5'd20, 4'hF, 32'hFFFFFFFF, 1, 0, 1, 5'd31, 4'hF, 32'hFFFFFFFF, q1, q2, v1, v2);
        bus_cycle(1, 1, 0, 5'd20, 4'h0, 32'h0, 1, 1, 0, 5'd17, 4'h0, 32'h0, q1, q2, v1, v2);
        total++; if (v1 !== 1'b1 || q1 !== 32'h0) begin bad++; $display("FAIL oob_rd1 got=%b/%h exp=1/0", v1, q1); end
        total++; if (v2 !== 1'b1 || q2 !== 32'h0) begin bad++; $display("FAIL oob_rd2 got=%b/%h exp=1/0", v2, q2); end
        for (int a = 0; a < DEPTH; a++) begin
            exp = model_read(AW'(a));
            bus_cycle(1, 1, 0, AW'(a), 4'h0, 32'h0, 0, 0, 0, '0, '0, '0, q1, q2, v1, v2);
            total++; if (v1 !== 1'b1 || q1 !== exp) begin bad++; $display("FAIL oob_keep a=%0d got=%b/%h exp=1/%h", a, v1, q1, exp); end
        end
    endtask

    task automatic test_random();
        logic c1, r1, w1, c2, r2, w2, ev1, ev2, v1, v2;
        logic [AW-1:0] a1, a2; logic [3:0] b1, b2; logic [31:0] d1, d2, e1, e2, q1, q2;
        for (int k = 0; k < 60; k++) begin
            c1 = ($urandom_range(0, 7) != 0); r1 = 1'($urandom); w1 = 1'($urandom);
            c2 = ($urandom_range(0, 7) != 0); r2 = 1'($urandom); w2 = 1'($urandom);
            a1 = AW'($urandom_range(0, 19)); a2 = ($urandom_range(0, 2) == 0) ? a1 : AW'($urandom_range(0, 19));
            b1 = 4'($urandom_range(0, 15)); b2 = 4'($urandom_range(0, 15)); d1 = $urandom; d2 = $urandom;
            ev1 = c1 & r1 & ~w1; ev2 = c2 & r2 & ~w2;
            e1 = model_read(a1); e2 = model_read(a2);
            if (c2 & w2) model_write(a2, d2, b2);
            if (c1 & w1) model_write(a1, d1, b1);
            bus_cycle(c1, r1, w1, a1, b1, d1, c2, r2, w2, a2, b2, d2, q1, q2, v1, v2);
            total++; if (v1 !== ev1) begin bad++; $display("FAIL rnd_v1 k=%0d got=%b exp=%b", k, v1, ev1); end
            total++; if (v2 !== ev2) begin bad++; $display("FAIL rnd_v2 k=%0d got=%b exp=%b", k, v2, ev2); end
            if (ev1) begin total++; if (q1 !== e1) begin bad++; $display("FAIL rnd_d1 k=%0d got=%h exp=%h", k, q1, e1); end end
            if (ev2) begin total++; if (q2 !== e2) begin bad++; $display("FAIL rnd_d2 k=%0d got=%h exp=%h", k, q2, e2); end end
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a [4]; logic [AW-1:0] b [4];
        logic ev; logic [31:0] e1, e2;
        for (int i = 0; i < 4; i++) begin a[i] = AW'($urandom_range(0, DEPTH - 1)); b[i] = AW'($urandom_range(0, 19)); end
        s1_chipselect = 1; s1_read = 1; s1_address = a[0];
        s2_chipselect = 1; s2_read = 1; s2_address = b[0];
        for (int j = 0; j < 7; j++) begin
            @(posedge clk); #1;
            if (j < 3) begin s1_address = a[j + 1]; s2_address = b[j + 1]; end
            else idle_bus();
            ev = (j >= LAT - 1) && (j < LAT + 3);
            total++; if (s1_readdatavalid !== ev || s2_readdatavalid !== ev) begin
                bad++; $display("FAIL b2b_valid j=%0d got=%b%b exp=%b", j, s1_readdatavalid, s2_readdatavalid, ev);
            end
            e1 = model_read(a[ev ? j - (LAT - 1) : 3]);
            e2 = model_read(b[ev ? j - (LAT - 1) : 3]);
            if (j >= LAT - 1) begin
                total++; if (s1_readdata !== e1 || s2_readdata !== e2) begin
                    bad++; $display("FAIL b2b_data j=%0d got=%h/%h exp=%h/%h", j, s1_readdata, s2_readdata, e1, e2);
                end
            end
        end
    endtask

    task automatic test_reset_req();
        logic [31:0] q1, q2, pat; logic v1, v2, hold_v; bit seen;
        pat = $urandom | 32'h1;
        bus_cycle(1, 0, 1, 5'd9, 4'hF, pat, 0, 0, 0, '0, '0, '0, q1, q2, v1, v2);
        model_write(5'd9, pat, 4'hF);
        reset_req = 1; #1;
        total++; if (s1_waitrequest !== 1'b1 || s2_waitrequest !== 1'b1) begin
            bad++; $display("FAIL rreq_wait got=%b%b exp=11", s1_waitrequest, s2_waitrequest);
        end
        total++; if (init_done !== 1'b1) begin bad++; $display("FAIL rreq_done got=%b exp=1", init_done); end
        s1_chipselect = 1; s1_read = 1; s1_address = 5'd9; s2_chipselect = 1; s2_read = 1; s2_address = 5'd9;
        @(posedge clk); #1; idle_bus(); reset_req = 0;
        seen = 0;
        repeat (LAT + 1) begin @(posedge clk); #1; if (s1_readdatavalid || s2_readdatavalid) seen = 1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rreq_accept got=%b exp=0", seen); end
        s1_chipselect = 1; s1_read = 1; s1_address = 5'd9;
        @(posedge clk); #1; idle_bus(); reset_req = 1;
        hold_v = s1_readdatavalid;
        total++; if (hold_v !== (LAT == 1)) begin bad++; $display("FAIL hold_first got=%b exp=%b", hold_v, LAT == 1); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++; if (s1_readdatavalid !== hold_v) begin bad++; $display("FAIL hold_rv i=%0d got=%b exp=%b", i, s1_readdatavalid, hold_v); end
        end
        reset_req = 0;
        @(posedge clk); #1;
        total++; if (s1_readdatavalid !== (LAT == 2)) begin bad++; $display("FAIL hold_rel got=%b exp=%b", s1_readdatavalid, LAT == 2); end
        total++; if (s1_readdata !== pat) begin bad++; $display("FAIL hold_data got=%h exp=%h", s1_readdata, pat); end
        @(posedge clk); #1;
        total++; if (s1_readdatavalid !== 1'b0) begin bad++; $display("FAIL hold_end got=%b exp=0", s1_readdatavalid); end
    endtask

    task automatic test_reset_mid_clear();
        logic [31:0] q1, q2, d; logic v1, v2; int first; bit early;
        for (int a = 0; a < DEPTH; a++) begin
            d = $urandom | 32'h100;
            bus_cycle(1, 0, 1, AW'(a), 4'hF, d, 0, 0, 0, '0, '0, '0, q1, q2, v1, v2);
        end
        reset = 1; @(posedge clk); #1; reset = 0;
        repeat (9) begin @(posedge clk); #1; end
        total++; if (init_done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b exp=0", init_done); end
        reset = 1; #1;
        total++; if (s1_waitrequest !== 1'b1) begin bad++; $display("FAIL mid_wait got=%b exp=1", s1_waitrequest); end
        @(posedge clk); #1;
        wait_clear(first, early);
        total++; if (first !== DEPTH + 1) begin bad++; $display("FAIL mid_len got=%0d exp=%0d", first, DEPTH + 1); end
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        for (int a = 0; a < DEPTH; a++) begin
            bus_cycle(0, 0, 0, '0, '0, '0, 1, 1, 0, AW'(a), 4'h0, 32'h0, q1, q2, v1, v2);
            total++; if (v2 !== 1'b1 || q2 !== 32'h0) begin bad++; $display("FAIL mid_zero a=%0d got=%b/%h exp=1/0", a, v2, q2); end
        end
        reset = 1; @(posedge clk); #1; reset = 0;
        first = 0;
        for (int c = 1; c <= 100 && first == 0; c++) begin
            @(posedge clk); #1;
            if (init_done) first = c;
            if (c == 4) reset_req = 1;
            if (c == 9) reset_req = 0;
        end
        reset_req = 0;
        total++; if (first !== DEPTH + 6) begin bad++; $display("FAIL pause_len got=%0d exp=%0d", first, DEPTH + 6); end
    endtask

    initial begin
        test_reset();
        test_clear_zero();
        test_byte_enable();
        test_write_collision();
        test_read_write_collision();
        test_out_of_range();
        test_random();
        test_back_to_back();
        test_reset_req();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
